// File: rtl/pixel_burst_packer.sv
// Packs camera pixel bytes into 64-bit little-endian words and queues them in a
// first-word-fall-through FIFO; a pulse announces every BURST_BEATS new words.
module pixel_burst_packer #(
  parameter int BURST_BEATS = 16,
  parameter int FIFO_DEPTH  = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  input  logic        frame_start,
  input  logic        start,
  input  logic        stop,
  output logic [63:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        burst_valid,
  output logic [31:0] drop_cnt,
  output logic [15:0] frame_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(BURST_BEATS) + 1;
  localparam logic [AW:0]   DEPTH_L   = (AW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_BEAT = PW'(BURST_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FRAME = 2'd1,
    S_RUN        = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [2:0]    r_byte_idx;
  logic [63:0]   r_word;
  logic [63:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [AW:0]   r_occ;
  logic [PW-1:0] r_pend;
  logic          r_burst;
  logic [31:0]   r_drop_cnt;
  logic [15:0]   r_frame_cnt;

  logic          w_first_pix;
  logic          w_pix_take;
  logic          w_word_done;
  logic          w_full;
  logic          w_wr_en;
  logic          w_drop;
  logic          w_rd_en;
  logic [63:0]   w_full_word;

  // A frame-start pixel always lands in byte 0, in WAIT_FRAME or mid-word in RUN.
  assign w_first_pix = !stop && pix_valid && frame_start &&
                       ((r_state == S_WAIT_FRAME) || (r_state == S_RUN));
  assign w_pix_take  = !stop && pix_valid && (r_state == S_RUN);
  assign w_word_done = w_pix_take && !frame_start && (r_byte_idx == 3'd7);
  assign w_full      = ((r_wr_ptr - r_rd_ptr) == DEPTH_L);
  assign w_wr_en     = w_word_done && !w_full;
  assign w_drop      = w_word_done && w_full;
  assign w_rd_en     = (r_occ != (AW+1)'(0)) && dout_ready;
  assign w_full_word = {pix_in, r_word[55:0]};

  assign dout_valid  = (r_occ != (AW+1)'(0));
  assign dout        = dout_valid ? r_mem[r_rd_ptr[AW-1:0]] : 64'h0;
  assign burst_valid = r_burst;
  assign drop_cnt    = r_drop_cnt;
  assign frame_cnt   = r_frame_cnt;

  // Capture state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; stop takes priority over every other command.
  always_comb begin
    w_state_next = r_state;
    if (stop) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_next = S_WAIT_FRAME;
          end else begin
            w_state_next = S_IDLE;
          end
        end
        S_WAIT_FRAME: begin
          if (pix_valid && frame_start) begin
            w_state_next = S_RUN;
          end else begin
            w_state_next = S_WAIT_FRAME;
          end
        end
        S_RUN: begin
          w_state_next = S_RUN;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // Byte packing, FIFO bookkeeping, burst accounting and statistics.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_byte_idx  <= 3'd0;
      r_word      <= 64'h0;
      r_wr_ptr    <= (AW+1)'(0);
      r_rd_ptr    <= (AW+1)'(0);
      r_occ       <= (AW+1)'(0);
      r_pend      <= PW'(0);
      r_burst     <= 1'b0;
      r_drop_cnt  <= 32'h0;
      r_frame_cnt <= 16'h0;
    end else begin
      r_burst <= 1'b0;

      if (stop) begin
        r_byte_idx <= 3'd0;
      end else if (w_first_pix) begin
        r_word[7:0] <= pix_in;
        r_byte_idx  <= 3'd1;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else if (w_pix_take) begin
        r_word[{r_byte_idx, 3'b000} +: 8] <= pix_in;
        r_byte_idx <= r_byte_idx + 3'd1;
      end else begin
        r_byte_idx <= r_byte_idx;
      end

      // Only words that actually enter the FIFO count toward a burst.
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
        if (r_pend == LAST_BEAT) begin
          r_pend  <= PW'(0);
          r_burst <= 1'b1;
        end else begin
          r_pend <= r_pend + PW'(1);
        end
      end

      if (w_drop && (r_drop_cnt != 32'hFFFF_FFFF)) begin
        r_drop_cnt <= r_drop_cnt + 32'd1;
      end

      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end

      case ({w_wr_en, w_rd_en})
        2'b10:   r_occ <= r_occ + (AW+1)'(1);
        2'b01:   r_occ <= r_occ - (AW+1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // FIFO storage; contents are masked on dout while empty, so no reset is needed.
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_full_word;
    end
  end

endmodule
